// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: operation select and FSM state.
// Also holds small decode helpers so the datapath reads in terms of intent.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CALC   = 2'b01,
        S_FINISH = 2'b10
    } div_state_e;

    function automatic logic op_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 divider, fixed DATA_WIDTH+1 cycle latency from accepted start to DoneE.
// BusyE stalls the pipeline for the whole operation; StartE is ignored unless idle.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StartE,
    input  logic                  FlushE,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic [1:0]            DivOpE,
    output logic                  BusyE,
    output logic                  DoneE,
    output logic [DATA_WIDTH-1:0] DivOutE
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    div_state_e    r_state;
    div_op_e       r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_div0;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_out;

    div_op_e       w_op_in;
    logic          w_sgn_in;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [W:0]    w_a_ext;
    logic [W:0]    w_b_ext;
    logic [W:0]    w_mag_a;
    logic [W:0]    w_mag_b;

    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_ge;
    logic [W-1:0]  w_rem_nxt;
    logic [W-1:0]  w_q_nxt;
    logic [W-1:0]  w_q_res;
    logic [W-1:0]  w_r_res;
    logic [W-1:0]  w_result;
    logic          w_last;
    logic          w_unused;

    assign w_op_in  = div_op_e'(DivOpE);
    assign w_sgn_in = op_signed(w_op_in);
    assign w_a_neg  = w_sgn_in & SrcAE[W-1];
    assign w_b_neg  = w_sgn_in & SrcBE[W-1];
    assign w_a_ext  = {w_a_neg, SrcAE};
    assign w_b_ext  = {w_b_neg, SrcBE};
    assign w_mag_a  = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_mag_b  = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;

    // Magnitudes never exceed 2**W-1 (most negative value gives exactly 2**(W-1)),
    // so the extra sign bit of each magnitude is always zero and is dropped on capture.
    assign w_shift   = {r_rem, r_q[W-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_rem_nxt = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
    assign w_q_nxt   = {r_q[W-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(W-1));

    // MIN/-1 needs no special case: magnitude 2**(W-1) with a positive sign wraps back to MIN.
    assign w_q_res = r_neg_q ? (~w_q_nxt + 1'b1) : w_q_nxt;
    assign w_r_res = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    always_comb begin
        w_result = '0;
        if (r_div0) begin
            w_result = op_rem(r_op) ? r_a : '1;
        end else begin
            w_result = op_rem(r_op) ? w_r_res : w_q_res;
        end
    end

    assign w_unused = &{1'b0, w_mag_a[W], w_mag_b[W], w_diff[W]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_DIV;
            r_a     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else if (FlushE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (StartE) begin
                        r_op    <= w_op_in;
                        r_a     <= SrcAE;
                        r_q     <= w_mag_a[W-1:0];
                        r_rem   <= '0;
                        r_dvs   <= w_mag_b[W-1:0];
                        r_cnt   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_div0  <= (SrcBE == '0);
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_q   <= w_q_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    // The final step's result is corrected and registered on this edge
                    // so DivOutE is already valid during the FINISH cycle with DoneE.
                    if (w_last) begin
                        r_out   <= w_result;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign BusyE   = r_busy;
    assign DoneE   = r_done;
    assign DivOutE = r_out;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes expected results and done cycles into a
// scoreboard; a negedge monitor pops and compares on every DoneE pulse.
module tb_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         StartE = 1'b0;
    logic         FlushE = 1'b0;
    logic [W-1:0] SrcAE  = '0;
    logic [W-1:0] SrcBE  = '0;
    logic [1:0]   DivOpE = 2'b00;
    logic         BusyE;
    logic         DoneE;
    logic [W-1:0] DivOutE;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .StartE  (StartE),
        .FlushE  (FlushE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .DivOpE  (DivOpE),
        .BusyE   (BusyE),
        .DoneE   (DoneE),
        .DivOutE (DivOutE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;
    int n_push  = 0;
    logic [W-1:0] last_exp = '0;

    logic [W-1:0] q_dat[$];
    int           q_cyc[$];
    string        q_nm[$];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (DoneE === 1'b1) begin
            n_done++;
            if (q_dat.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: DoneE=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                logic [W-1:0] e_dat;
                int           e_cyc;
                string        e_nm;
                e_dat = q_dat.pop_front();
                e_cyc = q_cyc.pop_front();
                e_nm  = q_nm.pop_front();
                check({e_nm, "_data"}, DivOutE, e_dat);
                check({e_nm, "_cycle"}, cyc, e_cyc);
            end
        end
    end

    // Called at a negedge with the FSM idle; returns at the negedge of cycle LAT+1.
    // mode 1: new start in cycle 5 (must be ignored); mode 2: start alongside DoneE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input string nm, input int mode);
        StartE = 1'b1;
        DivOpE = op;
        SrcAE  = a;
        SrcBE  = b;
        q_dat.push_back(exp);
        q_cyc.push_back(cyc + LAT);
        q_nm.push_back(nm);
        n_push++;
        last_exp = exp;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            StartE = 1'b0;
            SrcAE  = $urandom;
            SrcBE  = $urandom;
            DivOpE = 2'($urandom);
            if (mode == 1 && c == 5) begin
                StartE = 1'b1; SrcAE = 32'd1000; SrcBE = 32'd3; DivOpE = 2'b00;
            end
            if (mode == 2 && c == LAT) begin
                StartE = 1'b1; SrcAE = 32'd50; SrcBE = 32'd5; DivOpE = 2'b01;
            end
            if (c == 1 || c == LAT) check({nm, "_busy"}, W'(BusyE), 32'd1);
            if (c == LAT + 1)       check({nm, "_idle"}, W'(BusyE), 32'd0);
        end
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(BusyE), 32'd0);
        check("rst_done", W'(DoneE), 32'd0);
        check("rst_out",  DivOutE,   32'd0);

        // Start in the very first cycle after reset release.
        rst_n = 1'b1;
        run_op(2'b01, 32'd100,        32'd7,        32'd14,         "divu_100_7",   0);
        run_op(2'b11, 32'd100,        32'd7,        32'd2,          "remu_100_7",   0);
        run_op(2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  "div_m7_2",     0);
        run_op(2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  "rem_m7_2",     0);
        run_op(2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",      0);
        run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf",      0);
        run_op(2'b00, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF,  "div_by0",      0);
        run_op(2'b11, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9,  "remu_by0",     0);
        run_op(2'b10, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9,  "rem_by0",      0);
        run_op(2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2",     0);
        run_op(2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,         "rem_7_m2",     0);
        run_op(2'b01, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  "divu_max_1",   0);
        run_op(2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "divu_small",   0);
        run_op(2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "remu_small",   0);
        run_op(2'b00, 32'h8000_0000,  32'd1,        32'h8000_0000,  "div_min_1",    0);
        run_op(2'b01, 32'd100,        32'd7,        32'd14,         "divu_restart", 1);
        run_op(2'b11, 32'd23,         32'd5,        32'd3,          "remu_at_done", 2);
        run_op(2'b01, 32'd5,          32'd10,       32'd0,          "divu_after",   0);

        // Flush in cycle 10: no DoneE, result register untouched.
        d0 = n_done;
        StartE = 1'b1; DivOpE = 2'b01; SrcAE = 32'd1000; SrcBE = 32'd10;
        @(negedge clk);
        StartE = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", W'(BusyE), 32'd1);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        check("flush_busy_after", W'(BusyE), 32'd0);
        repeat (30) @(negedge clk);
        check("flush_out_held", DivOutE, last_exp);
        check("flush_no_done",  W'(n_done), W'(d0));

        // Reset in cycle 20 of an operation, then start in the release cycle.
        StartE = 1'b1; DivOpE = 2'b01; SrcAE = 32'd100; SrcBE = 32'd7;
        @(negedge clk);
        StartE = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", W'(BusyE), 32'd0);
        check("midrst_done", W'(DoneE), 32'd0);
        check("midrst_out",  DivOutE,   32'd0);
        rst_n = 1'b1;
        run_op(2'b11, 32'd100, 32'd7, 32'd2, "remu_post_rst", 0);

        repeat (5) @(negedge clk);
        check("sb_drained", W'(q_dat.size()), 32'd0);
        check("done_count", W'(n_done), W'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
